// File: rtl/d_ram_arbiter.sv
// Two-port arbiter in front of a single data RAM with independent read and write ports.
// Port 0 (CPU) wins conflicts unless port 1 has been starved for starve_limit cycles.
module d_ram_arbiter #(
  parameter int unsigned addr_width   = 11,
  parameter int unsigned data_width   = 8,
  parameter int unsigned starve_limit = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  we0,
  input  logic [addr_width-1:0] addr0,
  input  logic [data_width-1:0] wdata0,
  output logic                  gnt0,
  output logic [data_width-1:0] rdata0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic                  we1,
  input  logic [addr_width-1:0] addr1,
  input  logic [data_width-1:0] wdata1,
  output logic                  gnt1,
  output logic [data_width-1:0] rdata1,
  output logic                  rvalid1,
  output logic                  ram_w_en,
  output logic [addr_width-1:0] ram_w_addr,
  output logic [data_width-1:0] ram_din,
  output logic                  ram_r_en,
  output logic [addr_width-1:0] ram_r_addr,
  input  logic [data_width-1:0] ram_dout
);

  localparam logic [7:0] StarveLim = 8'(starve_limit);

  typedef enum logic [1:0] {OwnNone, OwnP0, OwnP1} owner_e;

  owner_e                r_owner;
  owner_e                w_owner_d;
  logic [7:0]            r_starve_cnt;
  logic [7:0]            w_starve_cnt_d;
  logic [data_width-1:0] r_rdata0;
  logic [data_width-1:0] r_rdata1;
  logic                  w_conflict;
  logic                  w_p1_wins;

  // Only same-type requests collide; a read and a write use separate RAM ports.
  assign w_conflict = req0 & req1 & (we0 == we1);
  assign w_p1_wins  = (r_starve_cnt >= StarveLim);

  assign gnt0 = rst & req0 & ~(w_conflict & w_p1_wins);
  assign gnt1 = rst & req1 & ~(w_conflict & ~w_p1_wins);

  always_comb begin
    ram_w_en   = 1'b0;
    ram_w_addr = addr0;
    ram_din    = wdata0;
    ram_r_en   = 1'b0;
    ram_r_addr = addr0;
    w_owner_d  = OwnNone;
    if (gnt0 && we0) begin
      ram_w_en = 1'b1;
    end else if (gnt1 && we1) begin
      ram_w_en   = 1'b1;
      ram_w_addr = addr1;
      ram_din    = wdata1;
    end
    if (gnt0 && !we0) begin
      ram_r_en  = 1'b1;
      w_owner_d = OwnP0;
    end else if (gnt1 && !we1) begin
      ram_r_en   = 1'b1;
      ram_r_addr = addr1;
      w_owner_d  = OwnP1;
    end
  end

  always_comb begin
    w_starve_cnt_d = r_starve_cnt;
    if (!req1 || gnt1) begin
      w_starve_cnt_d = 8'd0;
    end else if (r_starve_cnt != 8'hFF) begin
      w_starve_cnt_d = r_starve_cnt + 8'd1;
    end
  end

  assign rvalid0 = (r_owner == OwnP0);
  assign rvalid1 = (r_owner == OwnP1);

  // Forward the RAM output only on the valid cycle, otherwise replay the last value.
  assign rdata0 = rvalid0 ? ram_dout : r_rdata0;
  assign rdata1 = rvalid1 ? ram_dout : r_rdata1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner      <= OwnNone;
      r_starve_cnt <= 8'd0;
      r_rdata0     <= '0;
      r_rdata1     <= '0;
    end else begin
      r_owner      <= w_owner_d;
      r_starve_cnt <= w_starve_cnt_d;
      if (rvalid0) r_rdata0 <= ram_dout;
      if (rvalid1) r_rdata1 <= ram_dout;
    end
  end

endmodule

// File: tb/tb_d_ram_arbiter.sv
// Directed self-checking bench for d_ram_arbiter with a behavioural read-before-write RAM.
module tb_d_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [7:0]  rdata0, rdata1;
  logic        ram_w_en, ram_r_en;
  logic [10:0] ram_w_addr, ram_r_addr;
  logic [7:0]  ram_din, ram_dout;

  logic [7:0]  mem [0:2047];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;

  d_ram_arbiter #(
    .addr_width  (11),
    .data_width  (8),
    .starve_limit(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req0      (req0),
    .we0       (we0),
    .addr0     (addr0),
    .wdata0    (wdata0),
    .gnt0      (gnt0),
    .rdata0    (rdata0),
    .rvalid0   (rvalid0),
    .req1      (req1),
    .we1       (we1),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .gnt1      (gnt1),
    .rdata1    (rdata1),
    .rvalid1   (rvalid1),
    .ram_w_en  (ram_w_en),
    .ram_w_addr(ram_w_addr),
    .ram_din   (ram_din),
    .ram_r_en  (ram_r_en),
    .ram_r_addr(ram_r_addr),
    .ram_dout  (ram_dout)
  );

  always @(posedge clk) begin
    if (ram_r_en) ram_dout <= mem[ram_r_addr];
    if (ram_w_en) mem[ram_w_addr] <= ram_din;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
    req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
  endtask

  initial begin
    logic exp_g1, prev_g0, prev_g1;
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    mem[11'h020] = 8'h11;
    mem[11'h7FF] = 8'h5A;
    ram_dout = 8'h00;
    idle();
    rst = 1'b0;

    // Reset: request present but nothing granted or enabled
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h050; wdata0 = 8'hEE;
    @(negedge clk);
    check("rst_gnt0", gnt0, 0);
    check("rst_w_en", ram_w_en, 0);
    check("rst_rvalid0", rvalid0, 0);
    check("rst_cnt", dut.r_starve_cnt, 0);
    next_cycle();
    idle();
    rst = 1'b1;

    // Test 1: port 0 write then read
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h010; wdata0 = 8'hA5;
    @(negedge clk);
    check("t1_wr_gnt0", gnt0, 1);
    check("t1_w_en", ram_w_en, 1);
    check("t1_w_addr", ram_w_addr, 11'h010);
    check("t1_din", ram_din, 8'hA5);
    check("t1_wr_r_en", ram_r_en, 0);
    next_cycle();
    we0 = 1'b0;
    @(negedge clk);
    check("t1_rd_gnt0", gnt0, 1);
    check("t1_r_en", ram_r_en, 1);
    check("t1_rd_w_en", ram_w_en, 0);
    check("t1_r_addr", ram_r_addr, 11'h010);
    next_cycle();
    idle();
    @(negedge clk);
    check("t1_rvalid0", rvalid0, 1);
    check("t1_rdata0", rdata0, 8'hA5);
    check("t1_rvalid1", rvalid1, 0);
    next_cycle();
    @(negedge clk);
    check("t1_rvalid0_drop", rvalid0, 0);
    check("t1_rdata0_hold", rdata0, 8'hA5);

    // Test 2: both read continuously, port 1 wins every 5th cycle
    next_cycle();
    req0 = 1'b1; addr0 = 11'h001; req1 = 1'b1; addr1 = 11'h002;
    prev_g0 = 1'b0; prev_g1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_g1 = (i % 5 == 4);
      @(negedge clk);
      check($sformatf("t2_cnt_%0d", i), dut.r_starve_cnt, i % 5);
      check($sformatf("t2_gnt1_%0d", i), gnt1, exp_g1);
      check($sformatf("t2_gnt0_%0d", i), gnt0, !exp_g1);
      check($sformatf("t2_raddr_%0d", i), ram_r_addr, exp_g1 ? 11'h002 : 11'h001);
      check($sformatf("t2_rvalid0_%0d", i), rvalid0, prev_g0);
      check($sformatf("t2_rvalid1_%0d", i), rvalid1, prev_g1);
      prev_g0 = !exp_g1;
      prev_g1 = exp_g1;
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("t2_cnt_end", dut.r_starve_cnt, 0);
    check("t2_rvalid1_end", rvalid1, 1);

    // Test 3: same-address read and write from different ports
    next_cycle();
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h020;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h020; wdata1 = 8'h3C;
    @(negedge clk);
    check("t3_gnt0", gnt0, 1);
    check("t3_gnt1", gnt1, 1);
    check("t3_w_en", ram_w_en, 1);
    check("t3_r_en", ram_r_en, 1);
    check("t3_din", ram_din, 8'h3C);
    next_cycle();
    idle();
    @(negedge clk);
    check("t3_rvalid0", rvalid0, 1);
    check("t3_old_data", rdata0, 8'h11);
    next_cycle();
    req0 = 1'b1; addr0 = 11'h020;
    next_cycle();
    idle();
    @(negedge clk);
    check("t3_new_data", rdata0, 8'h3C);

    // Test 4: both write the same address, port 0 first
    next_cycle();
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h030; wdata0 = 8'h01;
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h030; wdata1 = 8'h02;
    @(negedge clk);
    check("t4_gnt0", gnt0, 1);
    check("t4_gnt1", gnt1, 0);
    check("t4_din0", ram_din, 8'h01);
    next_cycle();
    req0 = 1'b0;
    @(negedge clk);
    check("t4_cnt", dut.r_starve_cnt, 1);
    check("t4_gnt1_late", gnt1, 1);
    check("t4_waddr1", ram_w_addr, 11'h030);
    check("t4_din1", ram_din, 8'h02);
    next_cycle();
    idle();
    req0 = 1'b1; addr0 = 11'h030;
    next_cycle();
    idle();
    @(negedge clk);
    check("t4_final", rdata0, 8'h02);

    // Test 5: port 1 alone reads the top address
    next_cycle();
    req1 = 1'b1; addr1 = 11'h7FF;
    @(negedge clk);
    check("t5_gnt1", gnt1, 1);
    check("t5_gnt0", gnt0, 0);
    check("t5_raddr", ram_r_addr, 11'h7FF);
    next_cycle();
    idle();
    @(negedge clk);
    check("t5_rvalid1", rvalid1, 1);
    check("t5_rdata1", rdata1, 8'h5A);
    check("t5_cnt", dut.r_starve_cnt, 0);

    // Test 6: reset in the cycle after a granted read with counter at 3
    next_cycle();
    req0 = 1'b1; addr0 = 11'h001; req1 = 1'b1; addr1 = 11'h002;
    repeat (3) next_cycle();
    check("t6_cnt_pre", dut.r_starve_cnt, 3);
    check("t6_rvalid0_pre", rvalid0, 1);
    rst = 1'b0;
    we0 = 1'b1; addr0 = 11'h040; wdata0 = 8'h77;
    #1;
    check("t6_rvalid0", rvalid0, 0);
    check("t6_rvalid1", rvalid1, 0);
    check("t6_cnt", dut.r_starve_cnt, 0);
    @(negedge clk);
    check("t6_gnt0", gnt0, 0);
    check("t6_w_en", ram_w_en, 0);
    check("t6_r_en", ram_r_en, 0);
    next_cycle();
    check("t6_no_write", mem[11'h040], 8'h00);
    rst = 1'b1;
    req1 = 1'b0;
    @(negedge clk);
    check("t6_post_gnt0", gnt0, 1);
    check("t6_post_w_en", ram_w_en, 1);
    next_cycle();
    idle();
    req0 = 1'b1; addr0 = 11'h040;
    next_cycle();
    idle();
    @(negedge clk);
    check("t6_readback", rdata0, 8'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/d_ram_arbiter.md
Name: d_ram_arbiter

Overview:
- Shares the single data RAM (separate registered read port and write port, 1-cycle read latency) between two requesters.
- Port 0 is the CPU (priority). Port 1 is a secondary master, e.g. DMA or UART loader.
- Grants are combinational so the CPU sees zero wait when uncontested.
- A starvation counter guarantees port 1 progress.
- A read and a write from different ports are serviced in the same cycle, because the RAM has independent read and write ports.

Parameters:
- addr_width, 11, RAM address width.
- data_width, 8, RAM data width.
- starve_limit, 4, consecutive denied cycles of port 1 after which port 1 wins the next conflict (range 1..255).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-low.
- req0  input  1  port 0 access request.
- we0  input  1  port 0 access type: 1 = write, 0 = read.
- addr0  input  addr_width  port 0 address.
- wdata0  input  data_width  port 0 write data.
- gnt0  output  1  port 0 granted this cycle (combinational).
- rdata0  output  data_width  port 0 read data.
- rvalid0  output  1  rdata0 valid (registered).
- req1, we1, addr1, wdata1, gnt1, rdata1, rvalid1: same as port 0, for port 1.
- ram_w_en  output  1  RAM write enable.
- ram_w_addr  output  addr_width  RAM write address.
- ram_din  output  data_width  RAM write data.
- ram_r_en  output  1  RAM read enable.
- ram_r_addr  output  addr_width  RAM read address.
- ram_dout  input  data_width  RAM registered read data.

Behaviour:
- Reset (rst=0, asynchronous):
  - rvalid0 = rvalid1 = 0, starvation counter = 0, read-owner register = none.
  - gnt0/gnt1 = 0 while reset is asserted.
  - RAM enables = 0 while reset is asserted.
- Conflict definition: req0 & req1 & (we0 == we1).
  - Both reads, or both writes.
- Conflict resolution:
  - Winner is port 1 if starve_cnt >= starve_limit; otherwise port 0.
  - Loser gnt = 0 and must hold req/we/addr/wdata stable until granted.
- No conflict: every requesting port is granted in the same cycle.
  - Single requester: that port is granted.
  - One read plus one write: both are granted.
- Granted write, same cycle:
  - ram_w_en = 1.
  - ram_w_addr/ram_din come from the granted port.
- Granted read, same cycle:
  - ram_r_en = 1, ram_r_addr from the granted port.
  - Read-owner register <= that port.
  - Next cycle: rvalid of that port = 1, and its rdata = ram_dout.
  - Read latency is exactly 1 cycle after grant.
- rdataN holds its value when rvalidN = 0 (ram_dout is only forwarded by mux).
- rvalidN pulses for one cycle per granted read.
  - Back-to-back granted reads give consecutive rvalid pulses.
- Ungranted cycles:
  - ram_w_en = 0 and ram_r_en = 0.
  - Address and data outputs are don't-care; they are driven to port 0 values.
- Same-address read and write in the same cycle (different ports):
  - The read returns the OLD data (RAM read-before-write).
  - No forwarding.
- Starvation counter (8-bit, saturating at 255):
  - Increments when req1 = 1 and gnt1 = 0.
  - Clears to 0 when gnt1 = 1 or req1 = 0.
- Port 0 granted-on-idle: port 0 is never blocked by the counter when port 1 is not conflicting.
- Reset mid-operation:
  - Any pending rvalid is dropped.
  - The counter clears.
  - No RAM write occurs while rst = 0.

Test Plan:
1. Port 0 write addr 0x010 data 0xA5, then port 0 read 0x010 -> gnt0 = 1 both cycles; ram_w_en pulse; rvalid0 = 1 one cycle after the read grant with rdata0 = 0xA5.
2. Both ports read every cycle (addr0 = 0x001, addr1 = 0x002), starve_limit = 4 -> gnt0 for 4 cycles, gnt1 on the 5th, counter then 0; pattern repeats every 5 cycles; rvalid1 follows each gnt1 by 1 cycle.
3. Port 0 reads 0x020 while port 1 writes 0x020 = 0x3C (prior content 0x11) -> gnt0 = gnt1 = 1 same cycle; rdata0 = 0x11; a later read returns 0x3C.
4. Both ports write the same cycle (addr 0x030, data 0x01 / 0x02), counter 0 -> only port 0 is written; port 1 is written the following cycle; final mem[0x030] = 0x02.
5. Port 1 alone requests read 0x7FF (top address) -> gnt1 = 1 immediately; rvalid1 next cycle with the stored value; counter stays 0.
6. Assert rst low in the cycle after a granted read, with counter = 3 -> rvalid0/rvalid1 = 0 immediately; counter = 0; no ram_w_en during reset; first post-reset request is granted normally.
